// File: rtl/nap_pkg.sv
// Shared types and constants for the nap timer countdown controller.
package nap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StReq,
    StWait,
    StPause,
    StAlarm,
    StError
  } state_e;

  localparam logic [3:0] MAX_TENS_MS = 4'd5;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam bcd_time_t ZERO_TIME = '0;

  // True when every digit is a legal HH:MM:SS BCD value.
  function automatic logic time_is_valid(input bcd_time_t t);
    return (t.h10 <= MAX_DIGIT) && (t.h1 <= MAX_DIGIT) &&
           (t.m10 <= MAX_TENS_MS) && (t.m1 <= MAX_DIGIT) &&
           (t.s10 <= MAX_TENS_MS) && (t.s1 <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick once per second.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] r_cnt;

  // Terminal count wins over hold so a tick is never lost to a pause request.
  assign o_tick = i_en && (r_cnt == LastCnt);

  // Count while enabled; wrap on tick, freeze on hold, zero on clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en && !i_hold) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nap_timer_ctrl.sv
// Nap timer sequencer: owns the HH:MM:SS register, requests one decrement per
// second from the external BCD decrementer and raises the alarm at zero.
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned DEC_TIMEOUT   = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_load,
  input  logic       i_key_start,
  input  logic       i_key_cancel,
  input  logic [3:0] i_set_h10,
  input  logic [3:0] i_set_h1,
  input  logic [3:0] i_set_m10,
  input  logic [3:0] i_set_m1,
  input  logic [3:0] i_set_s10,
  input  logic [3:0] i_set_s1,
  output logic       o_dec_start,
  output logic [3:0] o_dec_h10,
  output logic [3:0] o_dec_h1,
  output logic [3:0] o_dec_m10,
  output logic [3:0] o_dec_m1,
  output logic [3:0] o_dec_s10,
  output logic [3:0] o_dec_s1,
  input  logic [3:0] i_dec_get_h10,
  input  logic [3:0] i_dec_get_h1,
  input  logic [3:0] i_dec_get_m10,
  input  logic [3:0] i_dec_get_m1,
  input  logic [3:0] i_dec_get_s10,
  input  logic [3:0] i_dec_get_s1,
  input  logic       i_dec_complete,
  input  logic       i_dec_is_zero,
  output logic [3:0] o_disp_h10,
  output logic [3:0] o_disp_h1,
  output logic [3:0] o_disp_m10,
  output logic [3:0] o_disp_m1,
  output logic [3:0] o_disp_s10,
  output logic [3:0] o_disp_s1,
  output logic       o_running,
  output logic       o_alarm,
  output logic       o_set_err,
  output logic       o_dec_err
);

  localparam int unsigned ToW = $clog2(DEC_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(DEC_TIMEOUT - 1);

  state_e         r_state;
  bcd_time_t      r_time;
  logic           r_pending_pause;
  logic [ToW-1:0] r_to_cnt;
  logic           r_dec_start;
  logic           r_alarm;
  logic           r_set_err;
  logic           r_dec_err;

  bcd_time_t w_set_time;
  bcd_time_t w_get_time;
  logic      w_time_zero;
  logic      w_tick;
  logic      w_presc_en;
  logic      w_presc_clr;

  assign w_set_time  = bcd_time_t'({i_set_h10, i_set_h1, i_set_m10,
                                    i_set_m1, i_set_s10, i_set_s1});
  assign w_get_time  = bcd_time_t'({i_dec_get_h10, i_dec_get_h1, i_dec_get_m10,
                                    i_dec_get_m1, i_dec_get_s10, i_dec_get_s1});
  assign w_time_zero = (r_time == ZERO_TIME);

  // The prescaler only runs in RUN; it restarts from zero after each capture.
  assign w_presc_en  = (r_state == StRun);
  assign w_presc_clr = i_key_cancel || (r_state == StIdle) ||
                       ((r_state == StWait) && i_dec_complete);

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_presc_en),
    .i_hold  (i_key_start),
    .i_clr   (w_presc_clr),
    .o_tick  (w_tick)
  );

  // Main sequencer with registered outputs and the time register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_time          <= ZERO_TIME;
      r_pending_pause <= 1'b0;
      r_to_cnt        <= '0;
      r_dec_start     <= 1'b0;
      r_alarm         <= 1'b0;
      r_set_err       <= 1'b0;
      r_dec_err       <= 1'b0;
    end else begin
      r_dec_start <= 1'b0;
      r_set_err   <= 1'b0;
      if (i_key_cancel) begin
        r_state         <= StIdle;
        r_time          <= ZERO_TIME;
        r_pending_pause <= 1'b0;
        r_alarm         <= 1'b0;
        r_dec_err       <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_key_load) begin
              if (time_is_valid(w_set_time)) r_time <= w_set_time;
              else                           r_set_err <= 1'b1;
            end else if (i_key_start && !w_time_zero) begin
              r_state <= StRun;
            end
          end
          StRun: begin
            if (w_tick) begin
              // A pause pressed on the tick cycle is honoured after the capture.
              if (i_key_start) r_pending_pause <= 1'b1;
              if (w_time_zero) begin
                r_state         <= StAlarm;
                r_alarm         <= 1'b1;
                r_pending_pause <= 1'b0;
              end else begin
                r_state     <= StReq;
                r_dec_start <= 1'b1;
              end
            end else if (i_key_start) begin
              r_state <= StPause;
            end
          end
          StReq: begin
            // Counts cycles since dec_start, the REQ cycle being the first.
            r_state  <= StWait;
            r_to_cnt <= ToW'(1);
            if (i_key_start) r_pending_pause <= 1'b1;
          end
          StWait: begin
            if (i_dec_complete) begin
              r_pending_pause <= 1'b0;
              if (i_dec_is_zero) begin
                r_state <= StAlarm;
                r_alarm <= 1'b1;
                r_time  <= ZERO_TIME;
              end else begin
                r_time  <= w_get_time;
                r_state <= (r_pending_pause || i_key_start) ? StPause : StRun;
              end
            end else begin
              if (i_key_start) r_pending_pause <= 1'b1;
              if (r_to_cnt == ToLast) begin
                r_state   <= StError;
                r_dec_err <= 1'b1;
              end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
              end
            end
          end
          StPause: begin
            if (i_key_start) r_state <= StRun;
          end
          StAlarm: begin
            r_time <= ZERO_TIME;
            if (i_key_start) begin
              r_state <= StIdle;
              r_alarm <= 1'b0;
            end
          end
          StError: begin
            r_state <= StError;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_running   = (r_state == StRun) || (r_state == StReq) || (r_state == StWait);
  assign o_dec_start = r_dec_start;
  assign o_alarm     = r_alarm;
  assign o_set_err   = r_set_err;
  assign o_dec_err   = r_dec_err;

  assign o_dec_h10  = r_time.h10;
  assign o_dec_h1   = r_time.h1;
  assign o_dec_m10  = r_time.m10;
  assign o_dec_m1   = r_time.m1;
  assign o_dec_s10  = r_time.s10;
  assign o_dec_s1   = r_time.s1;
  assign o_disp_h10 = r_time.h10;
  assign o_disp_h1  = r_time.h1;
  assign o_disp_m10 = r_time.m10;
  assign o_disp_m1  = r_time.m1;
  assign o_disp_s10 = r_time.s10;
  assign o_disp_s1  = r_time.s1;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Self-checking bench for nap_timer_ctrl: load-validation table, directed
// corner sequences and a randomized run against a seconds-based model.
module tb_nap_timer_ctrl;

  localparam int TPS = 4;
  localparam int DT  = 15;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MReq   = 2;
  localparam int MWait  = 3;
  localparam int MPause = 4;
  localparam int MAlarm = 5;
  localparam int MError = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load = 1'b0, key_start = 1'b0, key_cancel = 1'b0;
  logic [23:0] set_t = '0;
  logic [23:0] get_t = '0;
  logic        dec_complete = 1'b0, dec_is_zero = 1'b0;
  logic [23:0] dec_o, disp_o;
  logic        dec_start_o, running_o, alarm_o, set_err_o, dec_err_o;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state: remaining time kept as a plain count of seconds.
  int m_mode, m_secs, m_pre, m_req_cyc;
  bit m_pend, m_alarm, m_derr, m_serr, m_dstart;

  // Decrementer responder state.
  int resp_mode = 0;  // 0: latency 3, 1: random, 2: never completes, 3: latency 6
  bit r_busy = 1'b0, r_hold = 1'b0;
  int r_cnt = 0, r_in = 0;

  always #5 clk = ~clk;

  nap_timer_ctrl #(
    .TICKS_PER_SEC (TPS),
    .DEC_TIMEOUT   (DT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_key_load     (key_load),
    .i_key_start    (key_start),
    .i_key_cancel   (key_cancel),
    .i_set_h10      (set_t[23:20]),
    .i_set_h1       (set_t[19:16]),
    .i_set_m10      (set_t[15:12]),
    .i_set_m1       (set_t[11:8]),
    .i_set_s10      (set_t[7:4]),
    .i_set_s1       (set_t[3:0]),
    .o_dec_start    (dec_start_o),
    .o_dec_h10      (dec_o[23:20]),
    .o_dec_h1       (dec_o[19:16]),
    .o_dec_m10      (dec_o[15:12]),
    .o_dec_m1       (dec_o[11:8]),
    .o_dec_s10      (dec_o[7:4]),
    .o_dec_s1       (dec_o[3:0]),
    .i_dec_get_h10  (get_t[23:20]),
    .i_dec_get_h1   (get_t[19:16]),
    .i_dec_get_m10  (get_t[15:12]),
    .i_dec_get_m1   (get_t[11:8]),
    .i_dec_get_s10  (get_t[7:4]),
    .i_dec_get_s1   (get_t[3:0]),
    .i_dec_complete (dec_complete),
    .i_dec_is_zero  (dec_is_zero),
    .o_disp_h10     (disp_o[23:20]),
    .o_disp_h1      (disp_o[19:16]),
    .o_disp_m10     (disp_o[15:12]),
    .o_disp_m1      (disp_o[11:8]),
    .o_disp_s10     (disp_o[7:4]),
    .o_disp_s1      (disp_o[3:0]),
    .o_running      (running_o),
    .o_alarm        (alarm_o),
    .o_set_err      (set_err_o),
    .o_dec_err      (dec_err_o)
  );

  function automatic int bcd2sec(input logic [23:0] b);
    int h, m, s;
    h = int'(b[23:20]) * 10 + int'(b[19:16]);
    m = int'(b[15:12]) * 10 + int'(b[11:8]);
    s = int'(b[7:4]) * 10 + int'(b[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [23:0] sec2bcd(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // A digit set is legal exactly when it is the canonical form of its own value.
  function automatic bit bcd_ok(input logic [23:0] b);
    int s;
    s = bcd2sec(b);
    return (s < 100 * 3600) && (sec2bcd(s) == b);
  endfunction

  function automatic logic [52:0] act_vec();
    return {disp_o, dec_o, dec_start_o, running_o, alarm_o, set_err_o, dec_err_o};
  endfunction

  function automatic logic [52:0] exp_vec();
    bit run;
    run = (m_mode == MRun) || (m_mode == MReq) || (m_mode == MWait);
    return {sec2bcd(m_secs), sec2bcd(m_secs), m_dstart, run, m_alarm, m_serr, m_derr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_secs = 0; m_pre = 0; m_req_cyc = 0;
    m_pend = 0; m_alarm = 0; m_derr = 0; m_serr = 0; m_dstart = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    m_serr = 0;
    m_dstart = 0;
    if (key_cancel) begin
      m_mode = MIdle; m_secs = 0; m_alarm = 0; m_derr = 0; m_pend = 0; m_pre = 0;
      return;
    end
    case (m_mode)
      MIdle: begin
        if (key_load) begin
          if (bcd_ok(set_t)) m_secs = bcd2sec(set_t);
          else m_serr = 1;
        end else if (key_start && m_secs != 0) begin
          m_mode = MRun;
          m_pre = 0;
        end
      end
      MRun: begin
        if (m_pre == TPS - 1) begin
          m_pre = 0;
          if (m_secs == 0) begin
            m_mode = MAlarm; m_alarm = 1; m_pend = 0;
          end else begin
            m_mode = MReq; m_dstart = 1; m_pend = m_pend | key_start;
            m_req_cyc = cyc + 1;
          end
        end else if (key_start) begin
          m_mode = MPause;
        end else begin
          m_pre++;
        end
      end
      MReq: begin
        m_mode = MWait;
        m_pend = m_pend | key_start;
      end
      MWait: begin
        m_pend = m_pend | key_start;
        if (dec_complete) begin
          if (dec_is_zero) begin
            m_mode = MAlarm; m_alarm = 1; m_secs = 0;
          end else begin
            m_secs = bcd2sec(get_t);
            m_mode = m_pend ? MPause : MRun;
            m_pre = 0;
          end
          m_pend = 0;
        end else if (cyc + 1 - m_req_cyc == DT) begin
          m_mode = MError; m_derr = 1;
        end
      end
      MPause: if (key_start) m_mode = MRun;
      MAlarm: begin
        m_secs = 0;
        if (key_start) begin
          m_mode = MIdle; m_alarm = 0;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive the decrementer responder, compare, step, clear key pulses.
  task automatic cycle();
    dec_complete = 1'b0;
    dec_is_zero = 1'($urandom_range(0, 1));
    get_t = 24'($urandom);
    if (r_busy) begin
      r_cnt--;
      if (r_cnt == 0 && !r_hold) begin
        dec_complete = 1'b1;
        dec_is_zero = (r_in == 0);
        get_t = sec2bcd((r_in == 0) ? 0 : r_in - 1);
        r_busy = 1'b0;
      end
    end
    if (dec_start_o) begin
      r_busy = 1'b1;
      r_in = bcd2sec(dec_o);
      r_hold = (resp_mode == 2) || (resp_mode == 1 && $urandom_range(0, 11) == 0);
      case (resp_mode)
        1: r_cnt = int'($urandom_range(2, 6));
        3: r_cnt = 6;
        default: r_cnt = 3;
      endcase
    end
    check("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    key_load = 1'b0;
    key_start = 1'b0;
    key_cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [23:0] v);
    set_t = v;
    key_load = 1'b1;
    cycle();
  endtask

  task automatic do_start();
    key_start = 1'b1;
    cycle();
  endtask

  task automatic do_cancel();
    key_cancel = 1'b1;
    cycle();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("reset_async", 64'(act_vec()), 64'(exp_vec()));
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] digits;
    bit          exp_err;
    logic [23:0] exp_disp;
  } load_vec_t;

  load_vec_t vecs[10];

  initial begin
    int t0, t1;
    vecs[0] = '{24'h000003, 1'b0, 24'h000003};
    vecs[1] = '{24'h006000, 1'b1, 24'h000003};
    vecs[2] = '{24'h235959, 1'b0, 24'h235959};
    vecs[3] = '{24'h0A0000, 1'b1, 24'h235959};
    vecs[4] = '{24'h000060, 1'b1, 24'h235959};
    vecs[5] = '{24'h00000A, 1'b1, 24'h235959};
    vecs[6] = '{24'h995959, 1'b0, 24'h995959};
    vecs[7] = '{24'hF00000, 1'b1, 24'h995959};
    vecs[8] = '{24'h010000, 1'b0, 24'h010000};
    vecs[9] = '{24'h095959, 1'b0, 24'h095959};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(act_vec()), 64'd0);
    model_reset();
    rst_n = 1'b1;
    idle(2);

    // Load validation table
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].digits);
      check("load_set_err", 64'(set_err_o), 64'(vecs[i].exp_err));
      check("load_disp", 64'(disp_o), 64'(vecs[i].exp_disp));
      idle(1);
      check("set_err_one_cycle", 64'(set_err_o), 64'd0);
    end

    // Countdown 00:00:03 to alarm and acknowledge
    resp_mode = 0;
    do_cancel();
    do_load(24'h000003);
    do_start();
    idle(8);
    check("count_02", 64'(disp_o), 64'h000002);
    idle(8);
    check("count_01", 64'(disp_o), 64'h000001);
    idle(8);
    check("count_00", 64'(disp_o), 64'h000000);
    check("no_alarm_yet", 64'(alarm_o), 64'd0);
    idle(4);
    check("alarm_on", 64'(alarm_o), 64'd1);
    check("alarm_not_running", 64'(running_o), 64'd0);
    do_start();
    check("alarm_ack", 64'({alarm_o, running_o}), 64'd0);

    // Hour borrow 01:00:00 -> 00:59:59
    do_cancel();
    do_load(24'h010000);
    do_start();
    idle(4);
    check("req_pulse", 64'(dec_start_o), 64'd1);
    idle(1);
    check("req_single", 64'(dec_start_o), 64'd0);
    check("wait_dec_value", 64'(dec_o), 64'h010000);
    idle(2);
    check("wait_dec_stable", 64'(dec_o), 64'h010000);
    idle(1);
    check("borrow_result", 64'(disp_o), 64'h005959);

    // Pause mid-second, resume with held prescaler, then pause during WAIT
    do_cancel();
    do_load(24'h000010);
    do_start();
    idle(2);
    do_start();
    check("paused", 64'(running_o), 64'd0);
    idle(20);
    check("pause_frozen", 64'(disp_o), 64'h000010);
    do_start();
    idle(2);
    check("resume_held_presc", 64'(dec_start_o), 64'd1);
    idle(1);
    do_start();
    idle(2);
    check("wait_pause_disp", 64'(disp_o), 64'h000009);
    check("wait_pause_state", 64'(running_o), 64'd0);
    idle(10);
    check("wait_pause_frozen", 64'(disp_o), 64'h000009);

    // Decrementer timeout
    do_cancel();
    resp_mode = 2;
    do_load(24'h000005);
    do_start();
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      if (dec_start_o) t0 = cyc;
      else cycle();
    end
    for (int i = 0; i < 40 && t0 >= 0 && t1 < 0; i++) begin
      if (dec_err_o) t1 = cyc;
      else cycle();
    end
    check("timeout_latency", 64'(t1 - t0), 64'(DT));
    idle(5);
    do_start();
    check("dec_err_sticky", 64'(dec_err_o), 64'd1);
    do_cancel();
    check("cancel_clears", 64'({dec_err_o, running_o, disp_o}), 64'd0);

    // Reset during WAIT, late complete afterwards
    resp_mode = 3;
    do_load(24'h000005);
    do_start();
    idle(5);
    check("in_wait", 64'({running_o, dec_start_o}), 64'h2);
    apply_reset();
    idle(8);
    check("late_complete_ignored", 64'(act_vec()), 64'd0);

    // Randomized run against the model
    resp_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      key_cancel = ($urandom_range(0, 249) == 0);
      key_load = ($urandom_range(0, 24) == 0);
      key_start = ($urandom_range(0, 11) == 0);
      set_t = ($urandom_range(0, 3) != 0) ? sec2bcd(int'($urandom_range(0, 12))) : 24'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
